// File: rtl/dadda_mul_seq_if.sv
// Request/response bundle for dadda_mul_seq: operand request on the in_* side,
// product delivery on the out_* side.
interface dadda_mul_seq_if #(
    parameter int OP_BYTES = 2
);
    localparam int W = 8 * OP_BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [2*W-1:0] p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/dadda_mul_seq.sv
// Sequential OP_BYTES x OP_BYTES byte multiplier built around one shared 8x8 Dadda array.
// Optional build macro DADDA_MUL_SEQ_ZERO_SKIP_EN: zero operands bypass the MUL passes.

module dadda_8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] z
);
    localparam int D_SEQ [4] = '{6, 4, 3, 2};

    logic [7:0]  cur [16];
    logic [7:0]  nxt [16];
    int          ch  [16];
    int          nh  [16];
    int          k;
    logic [15:0] row0;
    logic [15:0] row1;

    // Column-wise Dadda reduction: each stage trims every column to D_SEQ[s] bits,
    // counting carries already pushed in from the column below.
    always_comb begin
        k = 0;
        for (int c = 0; c < 16; c++) begin
            cur[c] = '0;
            nxt[c] = '0;
            ch[c]  = 0;
            nh[c]  = 0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cur[4'(i + j)][3'(ch[4'(i + j)])] = x[i] & y[j];
                ch[4'(i + j)] = ch[4'(i + j)] + 1;
            end
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 16; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int c = 0; c < 16; c++) begin
                k = 0;
                for (int r = 0; r < 8; r++) begin
                    if (ch[c] - k + nh[c] > D_SEQ[s]) begin
                        if (ch[c] - k + nh[c] == D_SEQ[s] + 1) begin
                            nxt[c][3'(nh[c])] = cur[c][3'(k)] ^ cur[c][3'(k + 1)];
                            if (c < 15) begin
                                nxt[4'(c + 1)][3'(nh[4'(c + 1)])] = cur[c][3'(k)] & cur[c][3'(k + 1)];
                                nh[4'(c + 1)] = nh[4'(c + 1)] + 1;
                            end
                            k = k + 2;
                        end else begin
                            nxt[c][3'(nh[c])] = cur[c][3'(k)] ^ cur[c][3'(k + 1)] ^ cur[c][3'(k + 2)];
                            if (c < 15) begin
                                nxt[4'(c + 1)][3'(nh[4'(c + 1)])] =
                                    (cur[c][3'(k)] & cur[c][3'(k + 1)]) |
                                    (cur[c][3'(k)] & cur[c][3'(k + 2)]) |
                                    (cur[c][3'(k + 1)] & cur[c][3'(k + 2)]);
                                nh[4'(c + 1)] = nh[4'(c + 1)] + 1;
                            end
                            k = k + 3;
                        end
                        nh[c] = nh[c] + 1;
                    end
                end
                for (int r = 0; r < 8; r++) begin
                    if (r >= k && r < ch[c]) begin
                        nxt[c][3'(nh[c])] = cur[c][r];
                        nh[c] = nh[c] + 1;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                cur[c] = nxt[c];
                ch[c]  = nh[c];
            end
        end
        for (int c = 0; c < 16; c++) begin
            row0[c] = cur[c][0];
            row1[c] = cur[c][1];
        end
        z = row0 + row1;
    end
endmodule

// state | meaning
// IDLE  | waiting for a request, in_ready high
// MUL   | one byte-pair pass per cycle into acc
// DONE  | product on p, waiting for out_ready
module dadda_mul_seq #(
    parameter int OP_BYTES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dadda_mul_seq_if.slave   bus,
    output logic             busy
);
    localparam int W     = 8 * OP_BYTES;
    localparam int P_W   = 2 * W;
    localparam int IDX_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(OP_BYTES - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [P_W-1:0]   acc;
    logic [IDX_W-1:0] ia;
    logic [IDX_W-1:0] ib;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [15:0]      pp;
    logic [5:0]       shamt;
    logic [P_W-1:0]   pp_sh;
    logic             last_pass;
    logic             zero_op;

    assign a_byte    = a_q[8*ia +: 8];
    assign b_byte    = b_q[8*ib +: 8];
    assign shamt     = {3'(ia) + 3'(ib), 3'b000};
    assign pp_sh     = P_W'(pp) << shamt;
    assign last_pass = (ia == LAST) && (ib == LAST);
    assign bus.p     = acc;

`ifdef DADDA_MUL_SEQ_ZERO_SKIP_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    dadda_8 u_dadda (
        .x (a_byte),
        .y (b_byte),
        .z (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = zero_op ? DONE : MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (last_pass) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pass order: ia walks fastest, ib steps on each ia wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            ia  <= '0;
            ib  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        acc <= '0;
                        ia  <= '0;
                        ib  <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + pp_sh;
                    if (ia == LAST) begin
                        ia <= '0;
                        ib <= last_pass ? '0 : ib + 1'b1;
                    end else begin
                        ia <= ia + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dadda_mul_seq.sv
// Randomized self-checking bench for dadda_mul_seq at OP_BYTES = 1, 2 and 4,
// compared against plain integer multiplication and a pass-count latency model.
module tb_dadda_mul_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic busy1, busy2, busy4;
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef DADDA_MUL_SEQ_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    always #5 clk = ~clk;

    dadda_mul_seq_if #(.OP_BYTES(1)) bus1 ();
    dadda_mul_seq_if #(.OP_BYTES(2)) bus2 ();
    dadda_mul_seq_if #(.OP_BYTES(4)) bus4 ();

    dadda_mul_seq #(.OP_BYTES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));
    dadda_mul_seq #(.OP_BYTES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2));
    dadda_mul_seq #(.OP_BYTES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_product(input logic [63:0] a, input logic [63:0] b);
        return a * b;
    endfunction

    // Edges after the accept edge until out_valid: one per byte pair, or none when
    // a zero operand sends the request straight to DONE.
    function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b, input int opb);
        if (ZERO_SKIP && (a == 64'd0 || b == 64'd0)) return 0;
        return opb * opb;
    endfunction

    task automatic do_mul2(input logic [15:0] a, input logic [15:0] b, input int hold, input bit scramble);
        logic [63:0] exp_p;
        int          exp_lat, lat, busy_n;
        exp_p   = ref_product(64'(a), 64'(b));
        exp_lat = ref_latency(64'(a), 64'(b), 2);
        @(negedge clk);
        check("op2_in_ready_idle", 64'(bus2.in_ready), 64'd1);
        bus2.in_valid  = 1'b1;
        bus2.a         = a;
        bus2.b         = b;
        bus2.out_ready = 1'b0;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        if (scramble) begin
            bus2.a = 16'hAAAA;
            bus2.b = 16'hAAAA;
        end
        lat    = 0;
        busy_n = 0;
        while (!bus2.out_valid && lat < 40) begin
            busy_n += int'(busy2);
            @(posedge clk); #1;
            lat++;
        end
        check("op2_latency", 64'(lat), 64'(exp_lat));
        check("op2_busy_cycles", 64'(busy_n), 64'(exp_lat));
        check("op2_product", 64'(bus2.p), exp_p);
        repeat (hold) begin
            bus2.in_valid = 1'b1;
            bus2.a        = 16'($urandom);
            bus2.b        = 16'($urandom);
            @(posedge clk); #1;
            check("op2_hold_valid", 64'(bus2.out_valid), 64'd1);
            check("op2_hold_p", 64'(bus2.p), exp_p);
            check("op2_hold_in_ready", 64'(bus2.in_ready), 64'd0);
        end
        bus2.in_valid  = 1'b1;
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        check("op2_release_valid", 64'(bus2.out_valid), 64'd0);
        check("op2_release_in_ready", 64'(bus2.in_ready), 64'd1);
        check("op2_release_busy", 64'(busy2), 64'd0);
    endtask

    task automatic do_mul1(input logic [7:0] a, input logic [7:0] b);
        int lat;
        @(negedge clk);
        bus1.in_valid  = 1'b1;
        bus1.a         = a;
        bus1.b         = b;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("op1_latency", 64'(lat), 64'(ref_latency(64'(a), 64'(b), 1)));
        check("op1_product", 64'(bus1.p), ref_product(64'(a), 64'(b)));
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        check("op1_back_idle", 64'(bus1.in_ready), 64'd1);
    endtask

    task automatic do_mul4(input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(negedge clk);
        bus4.in_valid  = 1'b1;
        bus4.a         = a;
        bus4.b         = b;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("op4_latency", 64'(lat), 64'(ref_latency(64'(a), 64'(b), 4)));
        check("op4_product", bus4.p, ref_product(64'(a), 64'(b)));
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("op4_back_idle", 64'(bus4.in_ready), 64'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(bus2.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus2.out_valid), 64'd0);
        check("rst_p", 64'(bus2.p), 64'd0);
        check("rst_busy", 64'(busy2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul2(16'hFFFF, 16'hFFFF, 0, 1'b0);
        do_mul2(16'h1234, 16'h5678, 0, 1'b1);
        do_mul2(16'h00FF, 16'h0101, 10, 1'b0);
        do_mul2(16'h0000, 16'h1234, 0, 1'b0);
        do_mul2(16'h1234, 16'h0000, 2, 1'b1);

        // Reset lands after two of the four passes have accumulated into acc.
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.a        = 16'hFFFF;
        bus2.b        = 16'hFFFF;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus2.out_valid), 64'd0);
        check("midrst_p", 64'(bus2.p), 64'd0);
        check("midrst_busy", 64'(busy2), 64'd0);
        check("midrst_in_ready", 64'(bus2.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_mul2(16'h0003, 16'h0005, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            do_mul2(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        do_mul1(8'hFF, 8'hFF);
        do_mul1(8'h00, 8'h5A);
        for (int i = 0; i < 6; i++) do_mul1(8'($urandom), 8'($urandom));

        do_mul4(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mul4(32'h0000_0000, 32'h1234_5678);
        for (int i = 0; i < 4; i++) do_mul4($urandom, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
